// File: rtl/debug_pkg.sv
// -----------------------------------------------------------------------------
// debug_pkg
// Shared definitions for the debug serial path: word width, the reserved
// drop-report tag, the sender's state encoding and the queue FSM states.
// -----------------------------------------------------------------------------
package debug_pkg;

  localparam int         DBG_WORD_W   = 40;
  localparam logic [7:0] DBG_TAG_DROP = 8'hFF;

  // Sender-side state encoding as seen on its `state` output.
  localparam logic STATE_EMPTY  = 1'b0;
  localparam logic STATE_STORED = 1'b1;

  typedef enum logic [1:0] {
    DQ_IDLE,
    DQ_ISSUE,
    DQ_WAIT_BUSY,
    DQ_WAIT_DONE
  } dq_state_e;

  // In-band report of words lost to overflow: reserved tag, count in the
  // low byte of the payload.
  function automatic logic [DBG_WORD_W-1:0] drop_report(input logic [7:0] count);
    return {DBG_TAG_DROP, 24'h0, count};
  endfunction

endpackage

// File: rtl/debug_sync2.sv
// -----------------------------------------------------------------------------
// debug_sync2
// Two-flop synchronizer for out_clk -> in_clk crossings of quasi-static
// single-bit levels. Both flops clear on reset.
//   clk  : destination clock
//   rst  : asynchronous, active-high reset
//   d    : asynchronous input
//   q    : synchronized output (2-3 clk cycles after d changes)
// -----------------------------------------------------------------------------
module debug_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples the pre-edge value; blocking here would collapse the two stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debug_data_queue.sv
// -----------------------------------------------------------------------------
// debug_data_queue
// Collects 40-bit debug words into a small FIFO and feeds them, one at a time,
// to the debug serial sender through its store/data/state handshake. Words
// pushed while full are counted and later reported in-band with tag 8'hFF.
//   in_clk       : sole clock (the sender's in_clk)
//   reset        : asynchronous, active-high
//   push         : producer write strobe
//   push_data    : {tag[7:0], payload[31:0]}
//   full         : FIFO holds DEPTH words
//   level        : current word count
//   store        : one-cycle strobe to the sender
//   data         : word to the sender, stable until the sender leaves STORED
//   sender_state : sender state (0=EMPTY, 1=STORED), asynchronous
//   drop_count   : saturating count of dropped words not yet reported
//   timeout_err  : sticky, set when the sender never acknowledged a word
// -----------------------------------------------------------------------------
module debug_data_queue
  import debug_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                      in_clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DBG_WORD_W-1:0]     push_data,
  output logic                      full,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      store,
  output logic [DBG_WORD_W-1:0]     data,
  input  logic                      sender_state,
  output logic [7:0]                drop_count,
  output logic                      timeout_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  logic                  ss;
  dq_state_e             state, state_next;
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [TMR_W-1:0]      timer;
  logic [DBG_WORD_W-1:0] mem [DEPTH];

  logic fifo_empty;
  logic pop;
  logic report;
  logic wr_en;
  logic drop;
  logic timer_expire;

  debug_sync2 #(.WIDTH(1)) u_state_sync (
    .clk (in_clk),
    .rst (reset),
    .d   (sender_state),
    .q   (ss)
  );

  assign fifo_empty = (level == '0);
  assign full       = (level == LVL_W'(DEPTH));

  // Launch decisions: a queued word always wins over a pending drop report.
  assign pop    = (state == DQ_IDLE) && !fifo_empty && (ss == STATE_EMPTY);
  assign report = (state == DQ_IDLE) && fifo_empty && (drop_count != 8'd0) &&
                  (ss == STATE_EMPTY);

  // A pop in the same cycle frees a slot, so a push into a full FIFO lands.
  assign wr_en = push && (!full || pop);
  assign drop  = push && !wr_en;

  // Timer counts cycles spent in WAIT_BUSY; expiry is signalled as it reaches
  // TIMEOUT so the flag appears TIMEOUT+1 cycles after the store strobe.
  assign timer_expire = (state == DQ_WAIT_BUSY) && (ss == STATE_EMPTY) &&
                        (timer == TMR_W'(TIMEOUT - 1));

  assign store = (state == DQ_ISSUE);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) state <= DQ_IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next takes a default before the case so every path assigns
  // it and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      DQ_IDLE:      if (pop || report)            state_next = DQ_ISSUE;
      DQ_ISSUE:                                   state_next = DQ_WAIT_BUSY;
      DQ_WAIT_BUSY: if (ss == STATE_STORED)       state_next = DQ_WAIT_DONE;
                    else if (timer_expire)        state_next = DQ_IDLE;
      DQ_WAIT_DONE: if (ss == STATE_EMPTY)        state_next = DQ_IDLE;
      default:                                    state_next = DQ_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array is deliberately not reset; level and the pointers
  // define which entries are valid, so stale contents are never read.
  always_ff @(posedge in_clk) begin
    if (wr_en) mem[wr_ptr] <= push_data;
  end

  // ---------------------------------------------------------------------------
  // Pointers, level, output word, drop counter, timer, sticky error
  // ---------------------------------------------------------------------------
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      data        <= '0;
      drop_count  <= '0;
      timer       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(wr_en) - LVL_W'(pop);

      if (pop)         data <= mem[rd_ptr];
      else if (report) data <= drop_report(drop_count);

      // Reporting hands off the current count; a drop in the same cycle
      // starts the next count at one.
      if (report)                           drop_count <= drop ? 8'd1 : 8'd0;
      else if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;

      if (state == DQ_ISSUE)          timer <= '0;
      else if (state == DQ_WAIT_BUSY) timer <= timer + TMR_W'(1);

      if (timer_expire) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_debug_data_queue.sv
`timescale 1ns/1ps
module tb_debug_data_queue;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 255;
  localparam int LVL_W   = $clog2(DEPTH) + 1;
  localparam int BUSY    = 40;   // sender busy time in out_clk cycles

  logic             in_clk = 1'b0;
  logic             out_clk = 1'b0;
  logic             reset;
  logic             push;
  logic [39:0]      push_data;
  logic             full;
  logic [LVL_W-1:0] level;
  logic             store;
  logic [39:0]      data;
  logic             sender_state;
  logic [7:0]       drop_count;
  logic             timeout_err;

  // Sender model: either an automatic responder or a level the bench holds.
  logic auto_mode;
  logic auto_state;
  logic man_state;
  assign sender_state = auto_mode ? auto_state : man_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int double_store = 0;
  logic prev_store = 1'b0;

  logic [39:0] store_log[$];
  logic [39:0] exp_q[$];

  always #5 in_clk = ~in_clk;
  always #4 out_clk = ~out_clk;

  debug_data_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .in_clk       (in_clk),
    .reset        (reset),
    .push         (push),
    .push_data    (push_data),
    .full         (full),
    .level        (level),
    .store        (store),
    .data         (data),
    .sender_state (sender_state),
    .drop_count   (drop_count),
    .timeout_err  (timeout_err)
  );

  always @(posedge in_clk) cyc++;

  // Record every word handed to the sender and any store held two cycles.
  always @(negedge in_clk) begin
    if (store === 1'b1) store_log.push_back(data);
    if (store === 1'b1 && prev_store === 1'b1) double_store++;
    prev_store = store;
  end

  // Automatic sender: sees a store, goes STORED on the next out_clk, stays
  // busy BUSY out_clk cycles, then returns to EMPTY.
  initial begin
    auto_state = 1'b0;
    forever begin
      @(negedge in_clk);
      if (store === 1'b1) begin
        @(posedge out_clk);
        auto_state = 1'b1;
        repeat (BUSY) @(posedge out_clk);
        auto_state = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge in_clk);
  endtask

  task automatic push_one(input logic [39:0] w);
    push      = 1'b1;
    push_data = w;
    @(negedge in_clk);
    push      = 1'b0;
  endtask

  function automatic logic [39:0] rand_word();
    logic [7:0] tag;
    tag = 8'($urandom_range(0, 254));
    return {tag, 32'($urandom)};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_store"},   40'(store), 40'(0));
    check({tag, "_data"},    data, 40'(0));
    check({tag, "_full"},    40'(full), 40'(0));
    check({tag, "_level"},   40'(level), 40'(0));
    check({tag, "_drop"},    40'(drop_count), 40'(0));
    check({tag, "_timeout"}, 40'(timeout_err), 40'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycles(2);
    check_reset_outputs("reset");
    reset = 1'b0;
    cycles(1);
  endtask

  // Wait (bounded) for n logged stores, settle, then verify the exact count.
  task automatic wait_stores(input string tag, input int n, input int budget, input int settle);
    for (int i = 0; i < budget && store_log.size() < n; i++) @(negedge in_clk);
    cycles(settle);
    check({tag, "_count"}, 40'(store_log.size()), 40'(n));
  endtask

  task automatic compare_log(input string tag);
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_word%0d", tag, i),
            (i < store_log.size()) ? store_log[i] : 40'hx, exp_q[i]);
  endtask

  task automatic hold_sender();
    man_state = 1'b1;
    auto_mode = 1'b0;
    cycles(4);
  endtask

  initial begin
    logic [39:0] w, w1, w2;
    int n, c0, c1;

    reset     = 1'b1;
    push      = 1'b0;
    push_data = '0;
    auto_mode = 1'b1;
    man_state = 1'b0;
    cycles(1);
    do_reset();

    // --- Two back-to-back words through the automatic sender ---------------
    store_log.delete(); exp_q.delete();
    exp_q.push_back(40'h01_0000_0001);
    exp_q.push_back(40'h02_0000_0002);
    push_one(40'h01_0000_0001);
    push_one(40'h02_0000_0002);
    wait_stores("ab", 2, 500, 100);
    compare_log("ab");
    check("ab_level", 40'(level), 40'(0));

    // --- Random bursts, never more than DEPTH outstanding ------------------
    for (int r = 0; r < 3; r++) begin
      store_log.delete(); exp_q.delete();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        w = rand_word();
        exp_q.push_back(w);
        push_one(w);
        cycles($urandom_range(0, 3));
      end
      wait_stores($sformatf("rnd%0d", r), n, 2000, 100);
      compare_log($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_drop", r), 40'(drop_count), 40'(0));
    end

    // --- Overflow with sender held STORED, then drain plus report ----------
    hold_sender();
    store_log.delete(); exp_q.delete();
    for (int i = 0; i < DEPTH + 3; i++) begin
      w = rand_word();
      if (i < DEPTH) exp_q.push_back(w);
      push_one(w);
    end
    check("ovf_full", 40'(full), 40'(1));
    check("ovf_level", 40'(level), 40'(DEPTH));
    check("ovf_drop", 40'(drop_count), 40'(3));
    exp_q.push_back(40'hFF_0000_0003);
    auto_mode = 1'b1;
    wait_stores("ovf", DEPTH + 1, 3000, 100);
    compare_log("ovf");
    check("ovf_drop_clear", 40'(drop_count), 40'(0));
    check("ovf_level_end", 40'(level), 40'(0));

    // --- Sender never answers: timeout, next word still issued -------------
    auto_mode = 1'b0;
    man_state = 1'b0;
    cycles(4);
    w1 = rand_word();
    w2 = rand_word();
    push_one(w1);
    push_one(w2);
    c0 = -1;
    for (int i = 0; i < 50; i++) begin
      if (store === 1'b1) begin c0 = cyc; break; end
      @(negedge in_clk);
    end
    check("to_first_store", 40'(c0 >= 0), 40'(1));
    check("to_first_data", data, w1);
    c1 = -1;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      @(negedge in_clk);
      if (timeout_err === 1'b1) begin c1 = cyc; break; end
    end
    check("to_latency", 40'(c1 - c0), 40'(TIMEOUT + 1));
    c0 = -1;
    for (int i = 0; i < 20; i++) begin
      if (store === 1'b1) begin c0 = cyc; break; end
      @(negedge in_clk);
    end
    check("to_second_store", 40'(c0 >= 0), 40'(1));
    check("to_second_data", data, w2);
    cycles(TIMEOUT + 10);
    check("to_sticky", 40'(timeout_err), 40'(1));
    do_reset();

    // --- Push into a full FIFO in the cycle of a pop -----------------------
    hold_sender();
    store_log.delete(); exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      w = rand_word();
      exp_q.push_back(w);
      push_one(w);
    end
    check("pp_level_full", 40'(level), 40'(DEPTH));
    man_state = 1'b0;
    cycles(2);                // synchronizer delivers ss=0; pop this cycle
    w = rand_word();
    exp_q.push_back(w);
    push_one(w);
    auto_mode = 1'b1;         // auto_state is idle; it answers the store now up
    check("pp_level", 40'(level), 40'(DEPTH));
    check("pp_drop", 40'(drop_count), 40'(0));
    wait_stores("pp", DEPTH + 1, 3000, 100);
    compare_log("pp");
    check("pp_drop_end", 40'(drop_count), 40'(0));

    // --- Drop counter saturation -------------------------------------------
    hold_sender();
    store_log.delete(); exp_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      w = rand_word();
      exp_q.push_back(w);
      push_one(w);
    end
    push = 1'b1;
    for (int i = 0; i < 300; i++) begin
      push_data = rand_word();
      @(negedge in_clk);
    end
    push = 1'b0;
    check("sat_drop", 40'(drop_count), 40'(255));
    exp_q.push_back(40'hFF_0000_00FF);
    auto_mode = 1'b1;
    wait_stores("sat", DEPTH + 1, 3000, 100);
    compare_log("sat");

    // --- Reset while in WAIT_DONE with 5 words queued ----------------------
    store_log.delete();
    for (int i = 0; i < 6; i++) push_one(rand_word());
    for (int i = 0; i < 50 && store_log.size() < 1; i++) @(negedge in_clk);
    cycles(10);
    check("rst_mid_level", 40'(level), 40'(5));
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    cycles(1);
    reset = 1'b0;
    store_log.delete();
    cycles(100);
    check("rst_mid_no_store", 40'(store_log.size()), 40'(0));
    exp_q.delete();
    w = rand_word();
    exp_q.push_back(w);
    push_one(w);
    wait_stores("rst_after", 1, 500, 60);
    compare_log("rst_after");

    check("store_single_cycle", 40'(double_store), 40'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
